// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: window-scheduled, software-configured serial pattern detector.
// Holds the pattern configuration, runs detection over a bounded (or unbounded) window of
// valid samples, counts matches and pulses done when the window completes.
// Optional feature macro SEQ_DET_MASK_EN adds a per-bit compare mask (i_cfg_mask).
module seq_det_ctrl #(
    parameter int unsigned          PAT_W   = 8,
    parameter int unsigned          CNT_W   = 16,
    parameter logic [PAT_W-1:0]     DEF_PAT = PAT_W'(8'b0000_1011),
    parameter int unsigned          DEF_LEN = 4,
    localparam int unsigned         LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_cfg_overlap,
    input  logic [CNT_W-1:0] i_cfg_window,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] i_cfg_mask,
`endif
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_din_valid,
    input  logic             i_din,
    output logic             o_det,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_count_sat
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Configuration registers
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_window;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0] r_mask;
`endif

    // Run state
    state_e           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [CNT_W-1:0] r_smp;
    logic [CNT_W-1:0] r_match_count;
    logic             r_count_sat;
    logic             r_det;
    logic             r_busy;
    logic             r_done;

    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_len_mask;
    logic [PAT_W-1:0] w_cmp_mask;
    logic             w_hit;
    logic [CNT_W-1:0] w_smp_next;
    logic             w_win_end;
    logic [LEN_W-1:0] w_len_clamped;

    // Out-of-range lengths fall back to the full history width
    always_comb begin
        if (i_cfg_len == '0 || i_cfg_len > LEN_W'(PAT_W)) begin
            w_len_clamped = LEN_W'(PAT_W);
        end else begin
            w_len_clamped = i_cfg_len;
        end
    end

    // Candidate next history/fill and the match decision on that next history
    always_comb begin
        w_hist_next = {r_hist[PAT_W-2:0], i_din};
        w_fill_inc  = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
        w_len_mask  = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            w_len_mask[i] = (i < int'(r_len));
        end
`ifdef SEQ_DET_MASK_EN
        w_cmp_mask  = w_len_mask & r_mask;
`else
        w_cmp_mask  = w_len_mask;
`endif
        w_hit       = (((w_hist_next ^ r_pattern) & w_cmp_mask) == '0) && (w_fill_inc >= r_len);
        w_smp_next  = r_smp + CNT_W'(1);
        w_win_end   = (r_window != '0) && (w_smp_next == r_window);
    end

    // Configuration latch; writes are dropped while a run is active
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pattern <= DEF_PAT;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= 1'b1;
            r_window  <= '0;
`ifdef SEQ_DET_MASK_EN
            r_mask    <= '1;
`endif
        end else if (i_cfg_we && !r_busy) begin
            r_pattern <= i_cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= i_cfg_overlap;
            r_window  <= i_cfg_window;
`ifdef SEQ_DET_MASK_EN
            r_mask    <= i_cfg_mask;
`endif
        end
    end

    // Run controller FSM with registered det/busy/done and the sampling datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_hist        <= '0;
            r_fill        <= '0;
            r_smp         <= '0;
            r_match_count <= '0;
            r_count_sat   <= 1'b0;
            r_det         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_det  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state       <= StRun;
                        r_busy        <= 1'b1;
                        r_hist        <= '0;
                        r_fill        <= '0;
                        r_smp         <= '0;
                        r_match_count <= '0;
                        r_count_sat   <= 1'b0;
                    end
                end
                StRun: begin
                    // Abort wins over everything, including a sample in the same cycle
                    if (i_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (i_din_valid) begin
                        r_hist <= w_hist_next;
                        r_smp  <= w_smp_next;
                        // Non-overlap: a match consumes its bits, so restart the fill
                        r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
                        if (w_hit) begin
                            r_det <= 1'b1;
                            if (&r_match_count) begin
                                r_count_sat <= 1'b1;
                            end else begin
                                r_match_count <= r_match_count + CNT_W'(1);
                            end
                        end
                        if (w_win_end) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_det         = r_det;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_match_count = r_match_count;
    assign o_count_sat   = r_count_sat;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a default-width instance and a CNT_W=2 instance share stimulus;
// a bit-level model of each is checked against the DUTs on every falling clock edge.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_pattern = 8'h0B;
    logic [3:0]  cfg_len = 4'd4;
    logic        cfg_overlap = 1'b1;
    logic [15:0] cfg_window = 16'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;

    logic        det0, busy0, done0, sat0;
    logic [15:0] cnt0;
    logic        det1, busy1, done1, sat1;
    logic [1:0]  cnt1;

    int n_vec = 0;
    int n_bad = 0;
    int det_total = 0;
    int done_total = 0;
    int base_det;
    int base_done;

    always #5 clk = ~clk;

    seq_det_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_cfg_window(cfg_window),
        .i_start(start), .i_abort(abort), .i_din_valid(din_valid), .i_din(din),
        .o_det(det0), .o_busy(busy0), .o_done(done0), .o_match_count(cnt0),
        .o_count_sat(sat0)
    );

    seq_det_ctrl #(.CNT_W(2)) u_dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_cfg_window(cfg_window[1:0]),
        .i_start(start), .i_abort(abort), .i_din_valid(din_valid), .i_din(din),
        .o_det(det1), .o_busy(busy1), .o_done(done1), .o_match_count(cnt1),
        .o_count_sat(sat1)
    );

    // Model: mode 0 idle, 1 running, 2 finishing; history kept as a plain integer of past bits
    int m_st[2], m_hist[2], m_fresh[2], m_smp[2], m_cnt[2], m_sat[2], m_det[2];
    int m_pat[2], m_len[2], m_ovl[2], m_win[2];

    task automatic m_latch(int i, int mx);
        int ln;
        ln = (cfg_len == 0 || cfg_len > 8) ? 8 : int'(cfg_len);
        m_pat[i] = int'(cfg_pattern);
        m_len[i] = ln;
        m_ovl[i] = int'(cfg_overlap);
        m_win[i] = int'(cfg_window) & mx;
    endtask

    task automatic m_step(int i);
        int  mx;
        bit  hit;
        mx = (i == 0) ? 65535 : 3;
        m_det[i] = 0;
        if (m_st[i] == 0) begin
            if (cfg_we) m_latch(i, mx);
            if (start) begin
                m_st[i] = 1; m_hist[i] = 0; m_fresh[i] = 0; m_smp[i] = 0;
                m_cnt[i] = 0; m_sat[i] = 0;
            end
        end else if (m_st[i] == 1) begin
            if (abort) begin
                m_st[i] = 0;
            end else if (din_valid) begin
                m_hist[i] = ((m_hist[i] * 2) + int'(din)) % 256;
                if (m_fresh[i] < 8) m_fresh[i] = m_fresh[i] + 1;
                m_smp[i] = (m_smp[i] + 1) & mx;
                hit = (m_fresh[i] >= m_len[i]) &&
                      ((m_hist[i] % (1 << m_len[i])) == (m_pat[i] % (1 << m_len[i])));
                if (hit) begin
                    m_det[i] = 1;
                    if (m_cnt[i] == mx) m_sat[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                    if (m_ovl[i] == 0) m_fresh[i] = 0;
                end
                if (m_win[i] != 0 && m_smp[i] == m_win[i]) m_st[i] = 2;
            end
        end else begin
            if (cfg_we) m_latch(i, mx);
            m_st[i] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_hist[i] = 0; m_fresh[i] = 0; m_smp[i] = 0; m_cnt[i] = 0;
                m_sat[i] = 0; m_det[i] = 0; m_pat[i] = 8'h0B; m_len[i] = 4; m_ovl[i] = 1;
                m_win[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) m_step(i);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_all();
        chk("det0", int'(det0), m_det[0]);
        chk("busy0", int'(busy0), int'(m_st[0] == 1));
        chk("done0", int'(done0), int'(m_st[0] == 2));
        chk("count0", int'(cnt0), m_cnt[0]);
        chk("sat0", int'(sat0), m_sat[0]);
        chk("det1", int'(det1), m_det[1]);
        chk("busy1", int'(busy1), int'(m_st[1] == 1));
        chk("done1", int'(done1), int'(m_st[1] == 2));
        chk("count1", int'(cnt1), m_cnt[1]);
        chk("sat1", int'(sat1), m_sat[1]);
        if (det0) det_total++;
        if (done0) done_total++;
    endtask

    // Compare on the falling edge, then leave inputs changeable 1ns after the rising edge
    task automatic tick();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit v, input bit b);
        din_valid = v;
        din = b;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic stream(input bit [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) send(1'b1, bits[k]);
    endtask

    task automatic do_cfg(input bit [7:0] pat, input bit [3:0] len, input bit ovl,
                          input bit [15:0] win);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_window = win;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic mark();
        base_det = det_total;
        base_done = done_total;
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_det", int'(det0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_count", int'(cnt0), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Default config, overlapping 1011, unbounded window
        mark();
        do_start();
        stream(16'b1011011, 7);
        tick();
        chk("t1_dets", det_total - base_det, 2);
        chk("t1_count", int'(cnt0), 2);
        chk("t1_model_count", m_cnt[0], 2);
        chk("t1_no_done", done_total - base_done, 0);
        chk("t1_busy", int'(busy0), 1);
        do_abort();

        // Non-overlapping 1011
        do_cfg(8'h0B, 4'd4, 1'b0, 16'd0);
        mark();
        do_start();
        stream(16'b1011011, 7);
        tick();
        chk("t2_dets", det_total - base_det, 1);
        chk("t2_count", int'(cnt0), 1);
        do_abort();

        // Pattern 101, window 5
        do_cfg(8'h05, 4'd3, 1'b1, 16'd5);
        mark();
        do_start();
        stream(16'b10101, 5);
        chk("t3_done_now", int'(done0), 1);
        chk("t3_busy_now", int'(busy0), 0);
        chk("t3_det_now", int'(det0), 1);
        tick();
        chk("t3_done_gone", int'(done0), 0);
        chk("t3_count", int'(cnt0), 2);
        chk("t3_dets", det_total - base_det, 2);
        chk("t3_dones", done_total - base_done, 1);

        // Mid-run config write and restart are ignored; abort holds the count
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        mark();
        do_start();
        stream(16'b10, 2);
        do_cfg(8'h00, 4'd4, 1'b1, 16'd0);
        do_start();
        stream(16'b11, 2);
        stream(16'b011, 3);
        do_abort();
        chk("t4_busy", int'(busy0), 0);
        tick();
        chk("t4_count_held", int'(cnt0), 2);
        chk("t4_dets", det_total - base_det, 2);
        chk("t4_no_done", done_total - base_done, 0);

        // Gapped valid, then asynchronous reset mid-run
        do_cfg(8'hFB, 4'd4, 1'b0, 16'd8);
        mark();
        do_start();
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        chk("t5_det_now", int'(det0), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_det", int'(det0), 0);
        chk("t5_rst_busy", int'(busy0), 0);
        chk("t5_rst_count", int'(cnt0), 0);
        chk("t5_rst_done", int'(done0), 0);
        chk("t5_rst_sat", int'(sat1), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        // Defaults restored: overlap on, unbounded window
        mark();
        do_start();
        stream(16'b1011011011, 10);
        tick();
        chk("t5_post_dets", det_total - base_det, 3);
        chk("t5_post_no_done", done_total - base_done, 0);
        do_abort();

        // Saturation on the 2-bit counter instance
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        do_start();
        stream(16'hBBBB, 16);
        tick();
        chk("t6_small_count", int'(cnt1), 3);
        chk("t6_small_sat", int'(sat1), 1);
        chk("t6_model_small", m_cnt[1], 3);
        chk("t6_count", int'(cnt0), 4);
        chk("t6_sat", int'(sat0), 0);
        do_abort();

        // Length 0 clamps to full width; final sample of the window still matches
        do_cfg(8'b1011_0110, 4'd0, 1'b1, 16'd9);
        mark();
        do_start();
        stream(16'b0_1011_0110, 9);
        tick();
        chk("t7_dets", det_total - base_det, 1);
        chk("t7_dones", done_total - base_done, 1);
        chk("t7_count", int'(cnt0), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Controller around a programmable serial pattern detector.
- Holds the pattern configuration and arms and disarms detection with a start/abort handshake.
- Runs detection over a bounded window of valid input samples, counts matches and signals completion.
- Generalises the fixed 1011 overlapping detector into a software-configured, window-scheduled detection engine.

Parameters:
PAT_W, 8, maximum pattern length in bits (history register width)
CNT_W, 16, width of window length and match counter
DEF_PAT, 8'b0000_1011, reset value of pattern register (LSB = most recent bit)
DEF_LEN, 4, reset value of pattern length

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_we  input  1  config write strobe; honoured only when busy=0
cfg_pattern  input  PAT_W  pattern; bit 0 = last bit received
cfg_len  input  $clog2(PAT_W+1)  active pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
cfg_window  input  CNT_W  number of valid samples per run; 0 = unbounded
start  input  1  start request; accepted when busy=0
abort  input  1  stop current run
din_valid  input  1  din qualifier
din  input  1  serial data bit
det  output  1  one-cycle match pulse
busy  output  1  high in RUN
done  output  1  one-cycle pulse at window completion
match_count  output  CNT_W  matches in current/last run, saturating
count_sat  output  1  sticky, match_count saturated this run

Behaviour:
- Reset (rst=0, async): state IDLE; det=0, busy=0, done=0, match_count=0, count_sat=0; history=0, fill=0, sample counter=0; pattern=DEF_PAT, len=DEF_LEN, overlap=1, window=0.
- Config: on cfg_we with busy=0, latch all cfg_* on the clock edge.
  - Ignored when busy=1.
  - A cfg_len of 0 or greater than PAT_W is clamped to PAT_W.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start: clear history, fill, sample counter, match_count and count_sat; busy=1 from the next cycle.
  - RUN → IDLE on abort (priority over every other RUN event): no done pulse; match_count is held; a sample presented in the same cycle is discarded.
  - RUN → DONE when the sample counter reaches window (window≠0) on a valid sample; that final sample is still evaluated for a match.
  - DONE → IDLE unconditionally after 1 cycle. done=1 and busy=0 during DONE.
  - start in RUN or DONE is ignored.
- Sampling: only in RUN with din_valid=1.
  - history <= {history[PAT_W-2:0], din}.
  - fill saturates at PAT_W.
  - sample counter increments.
- Match: evaluated on the next-history value, with (history_next & lenmask) == (pattern & lenmask) and fill_next ≥ len.
  - lenmask = low len bits set.
- Match timing: det is registered and high for exactly the cycle after the edge that sampled the completing bit. det is never high for 2 consecutive cycles unless 2 consecutive valid samples each complete a match (e.g. len=1).
- Non-overlap mode: on a match, fill is cleared to 0, so the next match needs len fresh bits.
- Counting: match_count increments on each match. At all-ones it holds and sets count_sat.
- din_valid=0: history, fill and counters are held.

Optional Feature:
SEQ_DET_MASK_EN
- Defined: adds input cfg_mask [PAT_W], latched with cfg_we (reset all ones). Bits with mask=0 are don't-care in the compare.
- Undefined: port absent; exact compare over len bits.

Test Plan:
- Default cfg, start, window=0, overlap=1, stream 1,0,1,1,0,1,1 → det pulses after samples 4 and 7; match_count=2; no done.
- cfg overlap=0, pattern 1011, start, stream 1,0,1,1,0,1,1 → single det after sample 4; match_count=1.
- cfg pattern 101, len=3, window=5, start, stream 1,0,1,0,1 → det after samples 3 and 5; done pulse the cycle after sample 5 is sampled; busy drops; match_count=2.
- In RUN, pulse cfg_we with pattern 0000, then start again mid-run → both ignored; detection of 1011 continues unchanged; abort → busy=0, no done, count held.
- Gapped din_valid (1,–,0,–,1,1 with – = valid low) → one det; then rst low mid-run → all outputs 0 immediately, pattern back to DEF_PAT.
- CNT_W=2 build, stream of 1011 repeated 4 times, overlap=1 → match_count stops at 3; count_sat=1.
